// File: rtl/uart_byte_receiver_if.sv
// Purpose: serial line in, received byte plus status strobes out, for the UART receive path.
// Latency: none; this interface is wiring only.
// Backpressure: none; the consumer must take data_out in the cycle data_valid is high.
//
// Signals:
//   rx_serial      serial line from the PC, idles high
//   data_out       last correctly received byte, LSB = first data bit
//   data_valid     one-cycle strobe, data_out is new in that cycle
//   framing_error  one-cycle strobe, stop bit sampled low
//   busy           receiver is in the middle of a frame or waiting out a break
// Modports: master = the receiver, slave = the line driver / byte consumer.
interface uart_byte_receiver_if;
    logic       rx_serial;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    modport master (
        input  rx_serial,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );

    modport slave (
        output rx_serial,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_byte_receiver.sv
// Purpose: oversampled 8N1 UART receiver, one byte per good frame with a one-cycle strobe.
// Latency: data_valid about (9*OVERSAMPLE + OVERSAMPLE/2 + 2)*DIV + 3 clocks after the start edge.
// Backpressure: none; a byte whose strobe is missed is lost, there is no overrun flag.
//
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   rx_if     master side of uart_byte_receiver_if (rx_serial in; data_out,
//             data_valid, framing_error, busy out)
module uart_byte_receiver #(
    parameter int CLK_FREQ   = 12500000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    uart_byte_receiver_if.master  rx_if
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W    = $clog2(OVERSAMPLE);
    localparam int MID     = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    // The three vote points straddle the middle of the bit.
    localparam logic [SC_W-1:0]  SC_A     = SC_W'(MID - 1);
    localparam logic [SC_W-1:0]  SC_B     = SC_W'(MID);
    localparam logic [SC_W-1:0]  SC_C     = SC_W'(MID + 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);

    generate
        if (OVERSAMPLE < 8) begin : g_bad_oversample
            $error("uart_byte_receiver: OVERSAMPLE must be at least 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. Preset high so an idle line never looks like a
    // start edge as reset releases.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_if.rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,         state_d;
    logic [DIV_W-1:0] div_cnt_q,       div_cnt_d;
    logic [SC_W-1:0]  sc_q,            sc_d;
    logic [2:0]       bit_idx_q,       bit_idx_d;
    logic [1:0]       smp_q,           smp_d;
    logic [7:0]       shift_q,         shift_d;
    logic [7:0]       data_out_q,      data_out_d;
    logic             data_valid_q,    data_valid_d;
    logic             framing_error_q, framing_error_d;

    logic tick;
    logic maj;

    // The first two votes are held in smp_q; the third is the live rx_s
    // at the SC_C tick, so the decision is made in that same tick.
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            div_cnt_q       <= '0;
            sc_q            <= '0;
            bit_idx_q       <= '0;
            smp_q           <= '0;
            shift_q         <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            div_cnt_q       <= div_cnt_d;
            sc_q            <= sc_d;
            bit_idx_q       <= bit_idx_d;
            smp_q           <= smp_d;
            shift_q         <= shift_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        div_cnt_d       = div_cnt_q;
        sc_d            = sc_q;
        bit_idx_d       = bit_idx_q;
        smp_d           = smp_q;
        shift_d         = shift_q;
        data_out_d      = data_out_q;
        data_valid_d    = 1'b0;
        framing_error_d = 1'b0;
        tick            = 1'b0;

        // Sample-tick divider only runs while a frame is being timed.
        if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                if (!rx_s) begin
                    state_d   = ST_START;
                    sc_d      = '0;
                    bit_idx_d = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (sc_q == SC_A) smp_d[0] = rx_s;
                    if (sc_q == SC_B) smp_d[1] = rx_s;
                    if (sc_q == SC_C && maj) begin
                        // Line was back high mid-bit: a glitch, not a start bit.
                        state_d = ST_IDLE;
                        sc_d    = '0;
                    end else if (sc_q == SC_LAST) begin
                        state_d = ST_DATA;
                        sc_d    = '0;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (sc_q == SC_A) smp_d[0] = rx_s;
                    if (sc_q == SC_B) smp_d[1] = rx_s;
                    if (sc_q == SC_C) shift_d[bit_idx_q] = maj;
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (sc_q == SC_A) smp_d[0] = rx_s;
                    if (sc_q == SC_B) smp_d[1] = rx_s;
                    // Decide mid stop bit rather than at its end so a slightly
                    // fast transmitter's next start edge is not missed.
                    if (sc_q == SC_C) begin
                        sc_d = '0;
                        if (maj) begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            framing_error_d = 1'b1;
                            state_d         = ST_BREAK;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end

            ST_BREAK: begin
                // Wait for the line to return high so a held-low line
                // cannot be mistaken for a stream of start bits.
                if (rx_s) state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_if.data_out      = data_out_q;
    assign rx_if.data_valid    = data_valid_q;
    assign rx_if.framing_error = framing_error_q;
    assign rx_if.busy          = (state_q != ST_IDLE);

endmodule
